// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-queue round-robin register-file write arbiter
// with pending-write hazard detection for two read ports.
module rf_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_reg,
    input  logic [15:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_reg,
    input  logic [15:0] req1_data,
    output logic        rf_WriteReg,
    output logic [3:0]  rf_DstReg,
    output logic [15:0] rf_DstData,
    input  logic [3:0]  chk_reg1,
    input  logic [3:0]  chk_reg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        idle
);
    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [19:0]   entries [2][DEPTH];
    logic [AW-1:0] wrPtr [2];
    logic [AW-1:0] rdPtr [2];
    logic [AW:0]   count [2];
    logic [3:0]    reqReg [2];
    logic [15:0]   reqData [2];
    logic [1:0]    reqValid, reqReady, push, pop, nonEmpty;
    logic          lastGrant, grantIdx, hit1, hit2;

    assign reqValid   = {req1_valid, req0_valid};
    assign reqReg[0]  = req0_reg;
    assign reqReg[1]  = req1_reg;
    assign reqData[0] = req0_data;
    assign reqData[1] = req1_data;
    assign nonEmpty   = {count[1] != '0, count[0] != '0};
    assign reqReady   = {count[1] < FULL && !rst, count[0] < FULL && !rst};
    assign req0_ready = reqReady[0];
    assign req1_ready = reqReady[1];
    // Writes to R0 complete the handshake but never occupy a slot.
    assign push       = reqValid & reqReady & {reqReg[1] != 4'd0, reqReg[0] != 4'd0};
    assign grantIdx   = nonEmpty[1] && (!nonEmpty[0] || !lastGrant);
    assign pop        = nonEmpty == 2'b00 ? 2'b00 : (grantIdx ? 2'b10 : 2'b01);
    assign idle       = nonEmpty == 2'b00 && !rf_WriteReg;
    assign hazard1    = chk_reg1 != 4'd0 && hit1;
    assign hazard2    = chk_reg2 != 4'd0 && hit2;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hit1 = rf_WriteReg && rf_DstReg == chk_reg1;
        hit2 = rf_WriteReg && rf_DstReg == chk_reg2;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                if ({1'b0, AW'(i) - rdPtr[k]} < count[k]) begin
                    hit1 = hit1 || entries[k][i][19:16] == chk_reg1;
                    hit2 = hit2 || entries[k][i][19:16] == chk_reg2;
                end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                count[k] <= '0;
                wrPtr[k] <= '0;
                rdPtr[k] <= '0;
            end
            lastGrant   <= 1'b1;
            rf_WriteReg <= 1'b0;
            rf_DstReg   <= '0;
            rf_DstData  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    entries[k][wrPtr[k]] <= {reqReg[k], reqData[k]};
                    wrPtr[k]             <= wrPtr[k] + 1'b1;
                end
                if (pop[k])
                    rdPtr[k] <= rdPtr[k] + 1'b1;
                count[k] <= count[k] + (AW + 1)'(push[k]) - (AW + 1)'(pop[k]);
            end
            rf_WriteReg <= |nonEmpty;
            if (|nonEmpty) begin
                lastGrant               <= grantIdx;
                {rf_DstReg, rf_DstData} <= entries[grantIdx][rdPtr[grantIdx]];
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench; requester 0 writes R1-R7, requester 1 writes R8-R15
// so the monitor can attribute each register-file write to its source queue.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_reg, req1_reg, rf_DstReg, chk_reg1, chk_reg2;
    logic [15:0] req0_data, req1_data, rf_DstData;
    logic        rf_WriteReg, hazard1, hazard2, idle;

    int          nCmp = 0;
    int          nBad = 0;
    int          cyc = 0;
    int          wrCount = 0;
    int          firstCyc = 0;
    int          lastCyc = 0;
    logic [19:0] exp0[$];
    logic [19:0] exp1[$];
    bit          expSrc[$];
    logic [1:0]  rdyTab [10] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                                 2'b10, 2'b01, 2'b10, 2'b01};

    rf_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .rf_WriteReg(rf_WriteReg), .rf_DstReg(rf_DstReg), .rf_DstData(rf_DstData),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .hazard1(hazard1), .hazard2(hazard2), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nCmp++;
        if (act !== want) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Monitor: every register-file write must match the head of its source's queue.
    always @(negedge clk) begin
        cyc++;
        if (rf_WriteReg === 1'b1) begin
            if (rf_DstReg >= 4'd8) begin
                check("write_expected1", exp1.size() != 0, 1);
                if (exp1.size() != 0) check("write1", {rf_DstReg, rf_DstData}, exp1.pop_front());
            end else begin
                check("write_expected0", exp0.size() != 0, 1);
                if (exp0.size() != 0) check("write0", {rf_DstReg, rf_DstData}, exp0.pop_front());
            end
            if (expSrc.size() != 0) check("grant_order", rf_DstReg >= 4'd8, expSrc.pop_front());
            if (wrCount == 0) firstCyc = cyc;
            lastCyc = cyc;
            wrCount++;
        end
    end

    task automatic send(input bit who, input logic [3:0] r, input logic [15:0] d);
        int waitCyc = 0;
        if (who) begin
            req1_valid = 1'b1; req1_reg = r; req1_data = d;
        end else begin
            req0_valid = 1'b1; req0_reg = r; req0_data = d;
        end
        #1;
        while (!(who ? req1_ready : req0_ready) && waitCyc < 20) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        check(who ? "accept1" : "accept0", waitCyc < 20, 1);
        @(posedge clk);
        if (r != 4'd0) begin
            if (who) exp1.push_back({r, d});
            else exp0.push_back({r, d});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic burst(input int n, input bit chkRdy);
        int  i0 = 0;
        int  i1 = 0;
        int  k = 0;
        logic a0, a1;
        while ((i0 < n || i1 < n) && k < 100) begin
            req0_valid = i0 < n;
            req0_reg   = 4'(1 + i0 % 7);
            req0_data  = 16'hA000 + 16'(i0);
            req1_valid = i1 < n;
            req1_reg   = 4'(8 + i1 % 8);
            req1_data  = 16'hB000 + 16'(i1);
            #1;
            if (chkRdy && k < 10) check($sformatf("ready_e%0d", k), {req0_ready, req1_ready}, rdyTab[k]);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            if (a0) begin exp0.push_back({req0_reg, req0_data}); i0++; end
            if (a1) begin exp1.push_back({req1_reg, req1_data}); i1++; end
            @(negedge clk);
            k++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("burst_done", i0 == n && i1 == n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, nBad=%0d", nBad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_reg = 4'd2; req0_data = 16'h0BAD;
        req1_valid = 1'b0; req1_reg = 4'd0; req1_data = 16'h0;
        chk_reg1 = 4'd2; chk_reg2 = 4'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_wr", rf_WriteReg, 0);
            check("rst_idle", idle, 1);
            check("rst_hazard1", hazard1, 0);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        chk_reg1 = 4'd0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", idle, 1);
        check("post_rst_wr", rf_WriteReg, 0);

        wrCount = 0;
        for (int i = 0; i < 16; i++) expSrc.push_back(i[0]);
        burst(8, 1'b1);
        repeat (10) @(negedge clk);
        check("burst_writes", wrCount, 16);
        check("burst_span", lastCyc - firstCyc, 15);
        check("burst_left", exp0.size() + exp1.size() + expSrc.size(), 0);
        check("burst_idle", idle, 1);

        send(1'b0, 4'd3, 16'h1234);
        check("single_e0_wr", rf_WriteReg, 0);
        @(negedge clk);
        check("single_wr", rf_WriteReg, 1);
        check("single_reg", rf_DstReg, 3);
        check("single_data", rf_DstData, 16'h1234);
        @(negedge clk);
        check("single_after_wr", rf_WriteReg, 0);
        check("single_idle", idle, 1);

        send(1'b1, 4'd0, 16'hFFFF);
        for (int c = 0; c < 3; c++) begin
            check("r0_wr", rf_WriteReg, 0);
            check("r0_hazard1", hazard1, 0);
            check("r0_idle", idle, 1);
            @(negedge clk);
        end

        chk_reg1 = 4'd5; chk_reg2 = 4'd5;
        #1;
        check("hz_before", hazard1, 0);
        send(1'b0, 4'd5, 16'h0555);
        check("hz1_queued", hazard1, 1);
        check("hz2_queued", hazard2, 1);
        check("hz_queued_wr", rf_WriteReg, 0);
        @(negedge clk);
        check("hz1_inflight", hazard1, 1);
        check("hz_inflight_wr", rf_WriteReg, 1);
        check("hz_inflight_reg", rf_DstReg, 5);
        @(negedge clk);
        check("hz1_done", hazard1, 0);
        check("hz2_done", hazard2, 0);
        chk_reg1 = 4'd0; chk_reg2 = 4'd0;

        burst(3, 1'b0);
        chk_reg1 = 4'd3; chk_reg2 = 4'd10;
        #1;
        check("flush_hz1", hazard1, 1);
        check("flush_hz2", hazard2, 1);
        check("flush_pending0", exp0.size(), 2);
        check("flush_pending1", exp1.size(), 2);
        rst = 1'b1;
        #1;
        check("flush_ready0", req0_ready, 0);
        check("flush_ready1", req1_ready, 0);
        @(negedge clk);
        check("flush_wr", rf_WriteReg, 0);
        check("flush_idle", idle, 1);
        check("flush_hz1_clear", hazard1, 0);
        check("flush_hz2_clear", hazard2, 0);
        exp0.delete();
        exp1.delete();
        rst = 1'b0;
        chk_reg1 = 4'd0; chk_reg2 = 4'd0;
        repeat (6) @(negedge clk);
        check("flush_after_idle", idle, 1);
        check("flush_after_wr", rf_WriteReg, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
